// File: rtl/urv_multiply_pipe.sv
`default_nettype none
// ============================================================================
// Module   : urv_multiply_pipe
// Brief    : Pipelined RV32M/RV64M multiplier (MUL, MULH, MULHSU, MULHU) for
//            the uRV execute stage. Each operation carries a valid bit and a
//            destination tag. Supports a global stall and a flush (kill).
//            WIDTH in {16,32,64}, STAGES in 1..4.
// Revision : 1.0 - initial release
// ============================================================================
module urv_multiply_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             x_stall_i,
  input  logic             x_kill_i,
  input  logic             d_valid_i,
  input  logic [2:0]       d_fun_i,
  input  logic [WIDTH-1:0] d_rs1_i,
  input  logic [WIDTH-1:0] d_rs2_i,
  input  logic [TAG_W-1:0] d_tag_i,
  output logic             w_valid_o,
  output logic [WIDTH-1:0] w_rd_o,
  output logic [TAG_W-1:0] w_tag_o,
  output logic             busy_o
);

  // Extended operand width and the product width actually needed. Bits at
  // and above 2*WIDTH of the (2*WIDTH+2)-bit signed product never reach a
  // result, so the product is computed modulo 2^(2*WIDTH).
  localparam int OP_W  = WIDTH + 1;
  localparam int PR_W  = 2 * WIDTH;
  // Split point of rs2 for the two partial products (deep configurations).
  localparam int SPLIT = WIDTH / 2;

  // Sign-extend a WIDTH+1 extended operand to product width.
  function automatic logic [PR_W-1:0] sext_op(input logic [OP_W-1:0] v);
    return {{(PR_W-OP_W){v[OP_W-1]}}, v};
  endfunction

  // Signed upper slice of rs2, sign-extended to product width.
  function automatic logic [PR_W-1:0] b_upper(input logic [OP_W-1:0] v);
    return {{(PR_W-(OP_W-SPLIT)){v[OP_W-1]}}, v[OP_W-1:SPLIT]};
  endfunction

  // Unsigned lower slice of rs2, zero-extended to product width.
  function automatic logic [PR_W-1:0] b_lower(input logic [OP_W-1:0] v);
    return {{(PR_W-SPLIT){1'b0}}, v[SPLIT-1:0]};
  endfunction

  // --------------------------------------------------------------------------
  // Issue-side decode
  // --------------------------------------------------------------------------
  logic            in_valid;
  logic            in_hi;
  logic [OP_W-1:0] in_a;
  logic [OP_W-1:0] in_b;

  // Decode funct3 and extend both operands; divide codes are never accepted.
  always_comb begin
    in_valid = d_valid_i & ~d_fun_i[2];
    in_hi    = (d_fun_i[1:0] != 2'b00);
    // rs1 is signed for MUL, MULH, MULHSU; unsigned only for MULHU.
    in_a     = {(d_fun_i[1:0] != 2'b11) & d_rs1_i[WIDTH-1], d_rs1_i};
    // rs2 is signed for MUL and MULH; unsigned for MULHSU and MULHU.
    in_b     = {~d_fun_i[1] & d_rs2_i[WIDTH-1], d_rs2_i};
  end

  // --------------------------------------------------------------------------
  // Control path: valid bits and tags travel with the op
  // --------------------------------------------------------------------------
  logic [STAGES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q [STAGES];

  // Valid shift register: reset and kill clear it, stall holds it.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
    end else if (x_kill_i) begin
      valid_q <= '0;
    end else if (!x_stall_i) begin
      valid_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  // Tag shift register; the last entry is the registered tag output.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < STAGES; k++) begin
        tag_q[k] <= '0;
      end
    end else if (!x_stall_i) begin
      tag_q[0] <= d_tag_i;
      for (int k = 1; k < STAGES; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Data path: product arriving at the output register and its half select
  // --------------------------------------------------------------------------
  logic [PR_W-1:0] prod;
  logic            hi_sel;

  if (STAGES == 1) begin : g_s1
    // Single register: the whole multiply sits in front of the output.
    assign prod   = sext_op(in_a) * sext_op(in_b);
    assign hi_sel = in_hi;
  end else begin : g_sn
    logic [OP_W-1:0]   a_q;
    logic [OP_W-1:0]   b_q;
    logic [STAGES-2:0] hi_q;

    // Stage 1 captures the extended operands.
    always_ff @(posedge clk_i) begin
      if (!x_stall_i) begin
        a_q <= in_a;
        b_q <= in_b;
      end
    end

    // Result-half selector follows the op up to the stage feeding the output.
    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        hi_q <= '0;
      end else if (!x_stall_i) begin
        hi_q[0] <= in_hi;
        for (int k = 1; k < STAGES - 1; k++) begin
          hi_q[k] <= hi_q[k-1];
        end
      end
    end

    assign hi_sel = hi_q[STAGES-2];

    if (STAGES == 2) begin : g_s2
      // Full multiply between operand capture and the output register.
      assign prod = sext_op(a_q) * sext_op(b_q);
    end else begin : g_s34
      logic [PR_W-1:0] pp_lo_q;
      logic [PR_W-1:0] pp_hi_q;
      logic [PR_W-1:0] pp_sum;

      // Stage 2 forms two partial products: rs1 times each half of rs2.
      always_ff @(posedge clk_i) begin
        if (!x_stall_i) begin
          pp_lo_q <= sext_op(a_q) * b_lower(b_q);
          pp_hi_q <= sext_op(a_q) * b_upper(b_q);
        end
      end

      assign pp_sum = pp_lo_q + (pp_hi_q << SPLIT);

      if (STAGES == 3) begin : g_s3
        assign prod = pp_sum;
      end else begin : g_s4
        logic [PR_W-1:0] sum_q;

        // Stage 3 holds the recombined product ahead of the output register.
        always_ff @(posedge clk_i) begin
          if (!x_stall_i) begin
            sum_q <= pp_sum;
          end
        end

        assign prod = sum_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] rd_d;
  logic [WIDTH-1:0] rd_q;

  assign rd_d = hi_sel ? prod[PR_W-1:WIDTH] : prod[WIDTH-1:0];

  // Result register: cleared by reset, held by stall, left stale by kill.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_q <= '0;
    end else if (!x_stall_i) begin
      rd_q <= rd_d;
    end
  end

  assign w_valid_o = valid_q[STAGES-1];
  assign w_rd_o    = rd_q;
  assign w_tag_o   = tag_q[STAGES-1];
  assign busy_o    = |valid_q;

endmodule
`default_nettype wire

// File: tb/tb_urv_multiply_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_urv_multiply_pipe
// Brief    : Self-checking bench for urv_multiply_pipe. Three instances
//            (32/2, 16/3, 64/4) share one stimulus stream; each is compared
//            every cycle against an arithmetic reference, and the 32/2
//            instance is also checked against hand-computed literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_urv_multiply_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        kill;
  logic        d_valid;
  logic [2:0]  d_fun;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic [4:0]  d_tag;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          cnt;
    logic [63:0] res;
    logic [4:0]  tag;
  } op_t;

  always #5 clk = ~clk;

  // Reference result straight from the instruction definitions.
  function automatic logic [63:0] ref_mul(input logic [2:0] fun, input logic [63:0] a,
                                          input logic [63:0] b, input int w);
    logic [63:0]         mask;
    logic signed [129:0] sa;
    logic signed [129:0] sb;
    logic signed [129:0] p;
    logic [129:0]        sh;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    sa = $signed({66'd0, a & mask});
    sb = $signed({66'd0, b & mask});
    if (fun[1:0] != 2'b11 && a[w-1]) sa = sa - (130'sd1 <<< w);
    if (fun[1] == 1'b0 && b[w-1]) sb = sb - (130'sd1 <<< w);
    p  = sa * sb;
    sh = (fun[1:0] == 2'b00) ? p : (p >> w);
    return sh[63:0] & mask;
  endfunction

  // --------------------------------------------------------------------------
  // DUT instances with their per-cycle reference comparison
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int W = (gi == 0) ? 32 : (gi == 1) ? 16 : 64;
    localparam int S = (gi == 0) ? 2  : (gi == 1) ? 3  : 4;

    logic         w_valid;
    logic         busy;
    logic [W-1:0] w_rd;
    logic [4:0]   w_tag;

    op_t          q[$];
    logic         m_valid = 1'b0;
    logic [63:0]  m_rd    = '0;
    logic [4:0]   m_tag   = '0;
    logic         m_rst   = 1'b0;
    int           chk     = 0;
    int           fail    = 0;

    urv_multiply_pipe #(
      .WIDTH (W),
      .STAGES(S),
      .TAG_W (5)
    ) u_dut (
      .clk_i    (clk),
      .rst_n_i  (rst_n),
      .x_stall_i(stall),
      .x_kill_i (kill),
      .d_valid_i(d_valid),
      .d_fun_i  (d_fun),
      .d_rs1_i  (rs1[W-1:0]),
      .d_rs2_i  (rs2[W-1:0]),
      .d_tag_i  (d_tag),
      .w_valid_o(w_valid),
      .w_rd_o   (w_rd),
      .w_tag_o  (w_tag),
      .busy_o   (busy)
    );

    // Inputs change just after a falling edge, so at each falling edge they
    // are still the values the preceding rising edge sampled.
    always @(negedge clk) begin
      m_rst = 1'b0;
      if (!rst_n) begin
        q.delete();
        m_valid = 1'b0;
        m_rst   = 1'b1;
      end else if (kill) begin
        q.delete();
        m_valid = 1'b0;
      end else if (!stall) begin
        if (d_valid && !d_fun[2]) q.push_back('{S, ref_mul(d_fun, rs1, rs2, W), d_tag});
        for (int k = 0; k < q.size(); k++) q[k].cnt = q[k].cnt - 1;
        m_valid = 1'b0;
        if (q.size() > 0 && q[0].cnt == 0) begin
          m_valid = 1'b1;
          m_rd    = q[0].res;
          m_tag   = q[0].tag;
          void'(q.pop_front());
        end
      end

      chk++;
      if (w_valid !== m_valid) begin
        fail++;
        $display("FAIL cfg%0d valid actual=%b expected=%b t=%0t", gi, w_valid, m_valid, $time);
      end
      chk++;
      if (busy !== (q.size() != 0 || m_valid)) begin
        fail++;
        $display("FAIL cfg%0d busy actual=%b expected=%b t=%0t", gi, busy,
                 (q.size() != 0 || m_valid), $time);
      end
      if (m_valid || m_rst) begin
        chk++;
        if (64'(w_rd) !== (m_rst ? 64'd0 : m_rd)) begin
          fail++;
          $display("FAIL cfg%0d rd actual=%h expected=%h t=%0t", gi, w_rd,
                   (m_rst ? 64'd0 : m_rd), $time);
        end
        chk++;
        if (w_tag !== (m_rst ? 5'd0 : m_tag)) begin
          fail++;
          $display("FAIL cfg%0d tag actual=%0d expected=%0d t=%0t", gi, w_tag,
                   (m_rst ? 5'd0 : m_tag), $time);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed helpers
  // --------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] fun, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag,
                       input logic st, input logic kl);
    d_valid = v;
    d_fun   = fun;
    rs1     = a;
    rs2     = b;
    d_tag   = tag;
    stall   = st;
    kill    = kl;
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h0000_0000_8000_0000;
      4:       return 64'h0000_0000_0000_8000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Corner-value table: funct3, rs1, rs2, expected result (32-bit).
  logic [2:0]  t2_fun [5] = '{3'd1, 3'd3, 3'd3, 3'd2, 3'd1};
  logic [31:0] t2_a   [5] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] t2_exp [5] = '{32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};

  // Stall scenario, one row per cycle: inputs then expected output after it.
  logic        t3_v   [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
  logic [4:0]  t3_tag [9] = '{1, 2, 3, 3, 3, 3, 4, 0, 0};
  logic        t3_st  [9] = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
  logic        t3_ev  [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
  logic [4:0]  t3_et  [9] = '{0, 1, 1, 1, 1, 2, 3, 4, 0};
  logic [31:0] t3_er  [9] = '{0, 200, 200, 200, 200, 300, 400, 500, 0};

  initial begin
    rst_n = 1'b0;
    drive(0, 3'd0, 64'd0, 64'd0, 5'd0, 0, 0);
    tick();
    tick();
    check("reset_valid", 64'(g_dut[0].w_valid), 64'd0);
    check("reset_busy",  64'(g_dut[0].busy),    64'd0);
    check("reset_rd",    64'(g_dut[0].w_rd),    64'd0);
    check("reset_tag",   64'(g_dut[0].w_tag),   64'd0);
    rst_n = 1'b1;

    // Pin the reference against hand-worked results.
    check("model_mul_neg",   ref_mul(3'd0, 64'h7, 64'hFFFF_FFFD, 32), 64'hFFFF_FFEB);
    check("model_mulh_min",  ref_mul(3'd1, 64'h8000, 64'h8000, 16), 64'h4000);
    check("model_mulhsu_64", ref_mul(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64),
          64'hFFFF_FFFF_FFFF_FFFF);

    // Basic MUL with latency of two cycles and echoed tag.
    drive(1, 3'd0, 64'h0000_0000_0000_0007, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 0, 0);
    tick();
    check("t1_valid_early", 64'(g_dut[0].w_valid), 64'd0);
    drive(0, 3'd0, 64'd0, 64'd0, 5'd0, 0, 0);
    tick();
    check("t1_valid", 64'(g_dut[0].w_valid), 64'd1);
    check("t1_rd",    64'(g_dut[0].w_rd),    64'hFFFF_FFEB);
    check("t1_tag",   64'(g_dut[0].w_tag),   64'd5);
    tick();
    check("t1_valid_after", 64'(g_dut[0].w_valid), 64'd0);

    // High-half corner values issued back to back.
    for (int k = 0; k < 5; k++) begin
      drive(1, t2_fun[k], 64'(t2_a[k]), 64'(t2_a[k]), 5'(10 + k), 0, 0);
      tick();
      if (k > 0) begin
        check("t2_valid", 64'(g_dut[0].w_valid), 64'd1);
        check("t2_rd",    64'(g_dut[0].w_rd),    64'(t2_exp[k-1]));
        check("t2_tag",   64'(g_dut[0].w_tag),   64'(10 + k - 1));
      end
    end
    drive(0, 3'd0, 64'd0, 64'd0, 5'd0, 0, 0);
    tick();
    check("t2_rd_last", 64'(g_dut[0].w_rd), 64'(t2_exp[4]));
    tick();

    // Four ops with a three-cycle stall after the second issue.
    for (int k = 0; k < 9; k++) begin
      drive(t3_v[k], 3'd0, 64'(t3_tag[k] + 1), 64'd100, t3_tag[k], t3_st[k], 0);
      tick();
      check("t3_valid", 64'(g_dut[0].w_valid), 64'(t3_ev[k]));
      if (t3_ev[k]) begin
        check("t3_tag", 64'(g_dut[0].w_tag), 64'(t3_et[k]));
        check("t3_rd",  64'(g_dut[0].w_rd),  64'(t3_er[k]));
      end
    end

    // Kill together with stall and a new request, two ops in flight.
    drive(1, 3'd0, 64'd2, 64'd3, 5'd1, 0, 0);
    tick();
    drive(1, 3'd0, 64'd4, 64'd5, 5'd2, 0, 0);
    tick();
    drive(1, 3'd0, 64'd6, 64'd7, 5'd3, 1, 1);
    tick();
    check("t4_busy",  64'(g_dut[0].busy),    64'd0);
    check("t4_valid", 64'(g_dut[0].w_valid), 64'd0);
    drive(0, 3'd0, 64'd0, 64'd0, 5'd0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_valid_later", 64'(g_dut[0].w_valid), 64'd0);
    end

    // Reset with ops in flight, then a fresh op completes normally.
    drive(1, 3'd0, 64'd3, 64'd3, 5'd7, 0, 0);
    tick();
    drive(1, 3'd0, 64'd5, 64'd5, 5'd8, 0, 0);
    tick();
    rst_n = 1'b0;
    tick();
    check("t5_valid", 64'(g_dut[0].w_valid), 64'd0);
    check("t5_rd",    64'(g_dut[0].w_rd),    64'd0);
    check("t5_busy",  64'(g_dut[0].busy),    64'd0);
    rst_n = 1'b1;
    drive(1, 3'd0, 64'd6, 64'd7, 5'd9, 0, 0);
    tick();
    check("t5_valid_early", 64'(g_dut[0].w_valid), 64'd0);
    drive(0, 3'd0, 64'd0, 64'd0, 5'd0, 0, 0);
    tick();
    check("t5_new_valid", 64'(g_dut[0].w_valid), 64'd1);
    check("t5_new_rd",    64'(g_dut[0].w_rd),    64'd42);
    check("t5_new_tag",   64'(g_dut[0].w_tag),   64'd9);

    // Mixed random traffic across all three configurations.
    for (int n = 0; n < 4000; n++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
            5'($urandom_range(0, 31)), $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    drive(0, 3'd0, 64'd0, 64'd0, 5'd0, 0, 0);
    repeat (8) tick();

    checks   += g_dut[0].chk + g_dut[1].chk + g_dut[2].chk;
    failures += g_dut[0].fail + g_dut[1].fail + g_dut[2].fail;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
